bsg_bitwise_accum: RTL and testbench

Parametrised, sequential successor to the plain bitwise AND gate. Applies a selectable per-bit operation (AND, OR, XOR, ANDN) to two `width_p` operands arriving on a valid/ready input stream. It either returns one result per beat or folds a multi-beat group into a single accumulated word. Sits between a producer stream and a consumer using a one-element registered output with valid/yumi handshake.

---
 rtl/bsg_bitwise_accum_if.sv | 35 +++
 rtl/bsg_bitwise_accum.sv | 120 ++++++++++++
 tb/tb_bsg_bitwise_accum.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bsg_bitwise_accum_if.sv
// ============================================================================
// Module   : bsg_bitwise_accum_if
// Brief    : Operand stream in, result stream out, for bsg_bitwise_accum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bsg_bitwise_accum_if #(
    parameter int width_p       = 16,
    parameter int count_width_p = 8
);
    logic                     v_i;
    logic                     ready_o;
    logic [width_p-1:0]       a_i;
    logic [width_p-1:0]       b_i;
    logic [1:0]               op_i;
    logic                     acc_i;
    logic                     last_i;
    logic                     v_o;
    logic [width_p-1:0]       data_o;
    logic [count_width_p-1:0] count_o;
    logic                     yumi_i;

    modport slave (
        input  v_i, a_i, b_i, op_i, acc_i, last_i, yumi_i,
        output ready_o, v_o, data_o, count_o
    );

    modport master (
        output v_i, a_i, b_i, op_i, acc_i, last_i, yumi_i,
        input  ready_o, v_o, data_o, count_o
    );
endinterface

`default_nettype wire

// File: rtl/bsg_bitwise_accum.sv
// ============================================================================
// Module   : bsg_bitwise_accum
// Brief    : Per-bit AND/OR/XOR/ANDN, pairwise or folded over a beat group,
//            with a one-entry valid/yumi output register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_bitwise_accum #(
    parameter int width_p       = 16,
    parameter int count_width_p = 8
) (
    input  wire logic             clk_i,
    input  wire logic             reset_n_i,
    bsg_bitwise_accum_if.slave    io
);
    typedef enum logic [0:0] {
        eIDLE = 1'b0,
        eACC  = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [width_p-1:0]       acc_q, acc_d;
    logic [count_width_p-1:0] cnt_q, cnt_d;
    logic [1:0]               gop_q, gop_d;
    logic                     out_v_q, out_v_d;
    logic [width_p-1:0]       data_q, data_d;
    logic [count_width_p-1:0] count_q, count_d;

    logic                     ready;
    logic                     accept;
    logic [width_p-1:0]       beat_val;
    logic [width_p-1:0]       acc_next;
    logic [count_width_p-1:0] cnt_next;

    function automatic logic [width_p-1:0] apply_op(
        input logic [width_p-1:0] x,
        input logic [width_p-1:0] y,
        input logic [1:0]         op
    );
        case (op)
            2'd0:    apply_op = x & y;
            2'd1:    apply_op = x | y;
            2'd2:    apply_op = x ^ y;
            default: apply_op = x & ~y;
        endcase
    endfunction

    // Full throughput: a consumer taking the result frees the slot this cycle.
    assign ready  = reset_n_i & (~out_v_q | io.yumi_i);
    assign accept = io.v_i & ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        gop_d    = gop_q;
        out_v_d  = out_v_q & ~io.yumi_i;
        data_d   = data_q;
        count_d  = count_q;

        // Inside a group the latched op governs both the beat and the fold.
        beat_val = apply_op(io.a_i, io.b_i, (state_q == eACC) ? gop_q : io.op_i);
        acc_next = apply_op(acc_q, beat_val, gop_q);
        cnt_next = (cnt_q == {count_width_p{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        if (accept) begin
            if (state_q == eIDLE) begin
                if (io.acc_i) begin
                    gop_d = io.op_i;
                    acc_d = beat_val;
                    cnt_d = count_width_p'(1);
                end
                if (!io.acc_i || io.last_i) begin
                    out_v_d = 1'b1;
                    data_d  = beat_val;
                    count_d = count_width_p'(1);
                end else begin
                    state_d = eACC;
                end
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_next;
                if (io.last_i) begin
                    out_v_d = 1'b1;
                    data_d  = acc_next;
                    count_d = cnt_next;
                    state_d = eIDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= eIDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            gop_q   <= '0;
            out_v_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            gop_q   <= gop_d;
            out_v_q <= out_v_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign io.ready_o = ready;
    assign io.v_o     = out_v_q;
    assign io.data_o  = data_q;
    assign io.count_o = count_q;
endmodule

`default_nettype wire

// File: tb/tb_bsg_bitwise_accum.sv
// ============================================================================
// Module   : tb_bsg_bitwise_accum
// Brief    : Directed bench for bsg_bitwise_accum (default and 2-bit counter).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bsg_bitwise_accum;
    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    bsg_bitwise_accum_if #(.width_p(16), .count_width_p(8)) if0 ();
    bsg_bitwise_accum_if #(.width_p(16), .count_width_p(2)) if1 ();

    bsg_bitwise_accum #(.width_p(16), .count_width_p(8)) dut0 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (if0)
    );

    bsg_bitwise_accum #(.width_p(16), .count_width_p(2)) dut1 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic acc, input logic last,
                          input logic yumi);
        if0.v_i    = v;
        if0.a_i    = a;
        if0.b_i    = b;
        if0.op_i   = op;
        if0.acc_i  = acc;
        if0.last_i = last;
        if0.yumi_i = yumi;
    endtask

    task automatic drive1(input logic v, input logic [15:0] a, input logic [1:0] op,
                          input logic acc, input logic last);
        if1.v_i    = v;
        if1.a_i    = a;
        if1.b_i    = 16'h0000;
        if1.op_i   = op;
        if1.acc_i  = acc;
        if1.last_i = last;
        if1.yumi_i = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        drive0(1'b1, 16'hAAAA, 16'h5555, 2'd1, 1'b0, 1'b0, 1'b0);
        drive1(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
        step();
        step();

        // Reset state, beats during reset discarded
        chk("rst_v",     {31'd0, if0.v_o},    32'd0);
        chk("rst_data",  {16'd0, if0.data_o}, 32'd0);
        chk("rst_count", {24'd0, if0.count_o}, 32'd0);
        chk("rst_ready", {31'd0, if0.ready_o}, 32'd0);

        drive0(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, if0.ready_o}, 32'd1);

        // Pairwise AND
        drive0(1'b1, 16'hF0F0, 16'hFF00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive0(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("and_v",     {31'd0, if0.v_o},    32'd1);
        chk("and_data",  {16'd0, if0.data_o}, 32'h0000F000);
        chk("and_count", {24'd0, if0.count_o}, 32'd1);
        if0.yumi_i = 1'b1;
        step();
        if0.yumi_i = 1'b0;
        chk("yumi_clear", {31'd0, if0.v_o}, 32'd0);

        // Accumulate XOR over three beats; op_i/acc_i on later beats ignored
        drive0(1'b1, 16'h0001, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        drive0(1'b1, 16'h0002, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("xor_mid_v", {31'd0, if0.v_o}, 32'd0);
        drive0(1'b1, 16'h0004, 16'h0003, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk("xor_v",     {31'd0, if0.v_o},    32'd1);
        chk("xor_data",  {16'd0, if0.data_o}, 32'h00000004);
        chk("xor_count", {24'd0, if0.count_o}, 32'd3);

        // Backpressure: beat offered but refused while the result is held
        drive0(1'b1, 16'hFFFF, 16'h00FF, 2'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_ready", {31'd0, if0.ready_o}, 32'd0);
            chk("hold_data",  {16'd0, if0.data_o}, 32'h00000004);
            step();
        end
        if0.yumi_i = 1'b1;
        #1;
        chk("yumi_ready", {31'd0, if0.ready_o}, 32'd1);
        step();
        drive0(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("andn_v",     {31'd0, if0.v_o},    32'd1);
        chk("andn_data",  {16'd0, if0.data_o}, 32'h0000FF00);
        chk("andn_count", {24'd0, if0.count_o}, 32'd1);

        // ANDN with b all-ones, replacing the held result in the same cycle
        drive0(1'b1, 16'h1234, 16'hFFFF, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        drive0(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("andn1_v",    {31'd0, if0.v_o},    32'd1);
        chk("andn1_data", {16'd0, if0.data_o}, 32'h00000000);
        if0.yumi_i = 1'b1;
        step();
        if0.yumi_i = 1'b0;

        // Reset mid-group discards the partial OR group
        drive0(1'b1, 16'h1111, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive0(1'b1, 16'h2222, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive0(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst_v",    {31'd0, if0.v_o},    32'd0);
        chk("midrst_data", {16'd0, if0.data_o}, 32'd0);
        drive0(1'b1, 16'h00FF, 16'h0F0F, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive0(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("single_v",     {31'd0, if0.v_o},    32'd1);
        chk("single_data",  {16'd0, if0.data_o}, 32'h0000000F);
        chk("single_count", {24'd0, if0.count_o}, 32'd1);
        if0.yumi_i = 1'b1;
        step();
        if0.yumi_i = 1'b0;

        // Group op lock: AND latched, OR on beat 2 ignored
        drive0(1'b1, 16'hFF00, 16'hFFFF, 2'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive0(1'b1, 16'hFFFF, 16'h00F0, 2'd1, 1'b0, 1'b1, 1'b0);
        step();
        drive0(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("lock_v",     {31'd0, if0.v_o},    32'd1);
        chk("lock_data",  {16'd0, if0.data_o}, 32'h00000000);
        chk("lock_count", {24'd0, if0.count_o}, 32'd2);

        // Counter saturation on the 2-bit counter instance
        drive1(1'b1, 16'h0001, 2'd1, 1'b1, 1'b0);
        step();
        drive1(1'b1, 16'h0002, 2'd1, 1'b0, 1'b0);
        step();
        drive1(1'b1, 16'h0004, 2'd1, 1'b0, 1'b0);
        step();
        drive1(1'b1, 16'h0008, 2'd1, 1'b0, 1'b0);
        step();
        drive1(1'b1, 16'h0010, 2'd1, 1'b0, 1'b1);
        step();
        drive1(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
        chk("sat_v",     {31'd0, if1.v_o},    32'd1);
        chk("sat_data",  {16'd0, if1.data_o}, 32'h0000001F);
        chk("sat_count", {30'd0, if1.count_o}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
